// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter in front of a single shared memory with fixed access latency.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break; default build gives the CPU fixed priority.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic        grant_dma_r, grant_dma_nxt_s;
    logic [31:0] mem_addr_r, mem_addr_nxt_s;
    logic [31:0] mem_wdata_r, mem_wdata_nxt_s;
    logic        mem_rd_r, mem_rd_nxt_s;
    logic        mem_wr_r, mem_wr_nxt_s;
    logic [31:0] cpu_rdata_r, cpu_rdata_nxt_s;
    logic [31:0] dma_rdata_r, dma_rdata_nxt_s;
    logic        cpu_ack_r, cpu_ack_nxt_s;
    logic        dma_ack_r, dma_ack_nxt_s;
    logic        pick_dma_s;
    logic        pick_we_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_dma_r, last_dma_nxt_s;

    // Tie goes to whichever port was not served by the previous grant.
    assign pick_dma_s = dma_req & (~cpu_req | ~last_dma_r);
`else
    // CPU wins every tie.
    assign pick_dma_s = dma_req & ~cpu_req;
`endif

    assign pick_we_s = pick_dma_s ? dma_we : cpu_we;

    assign cpu_rdata = cpu_rdata_r;
    assign dma_rdata = dma_rdata_r;
    assign cpu_ack   = cpu_ack_r;
    assign dma_ack   = dma_ack_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_rd    = mem_rd_r;
    assign mem_wr    = mem_wr_r;

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        grant_dma_nxt_s = grant_dma_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        mem_rd_nxt_s    = mem_rd_r;
        mem_wr_nxt_s    = mem_wr_r;
        cpu_rdata_nxt_s = cpu_rdata_r;
        dma_rdata_nxt_s = dma_rdata_r;
        cpu_ack_nxt_s   = 1'b0;
        dma_ack_nxt_s   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_dma_nxt_s  = last_dma_r;
`endif
        case (state_r)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_dma_nxt_s = pick_dma_s;
                    mem_addr_nxt_s  = pick_dma_s ? dma_addr  : cpu_addr;
                    mem_wdata_nxt_s = pick_dma_s ? dma_wdata : cpu_wdata;
                    mem_rd_nxt_s    = ~pick_we_s;
                    mem_wr_nxt_s    = pick_we_s;
                    cnt_nxt_s       = CNT_LOAD;
                    state_nxt_s     = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_dma_nxt_s  = pick_dma_s;
`endif
                end else begin
                    mem_rd_nxt_s = 1'b0;
                    mem_wr_nxt_s = 1'b0;
                end
            end
            ACCESS: begin
                if (cnt_r == 4'd0) begin
                    // Last strobe cycle: capture memory data and raise the granted ack.
                    if (grant_dma_r) begin
                        dma_rdata_nxt_s = mem_rdata;
                        dma_ack_nxt_s   = 1'b1;
                    end else begin
                        cpu_rdata_nxt_s = mem_rdata;
                        cpu_ack_nxt_s   = 1'b1;
                    end
                    mem_rd_nxt_s = 1'b0;
                    mem_wr_nxt_s = 1'b0;
                    state_nxt_s  = DONE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                mem_rd_nxt_s = 1'b0;
                mem_wr_nxt_s = 1'b0;
                state_nxt_s  = IDLE;
            end
        endcase
    end

    // State and registered-output update; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            grant_dma_r <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            cpu_rdata_r <= 32'd0;
            dma_rdata_r <= 32'd0;
            cpu_ack_r   <= 1'b0;
            dma_ack_r   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dma_r  <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            grant_dma_r <= grant_dma_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            mem_rd_r    <= mem_rd_nxt_s;
            mem_wr_r    <= mem_wr_nxt_s;
            cpu_rdata_r <= cpu_rdata_nxt_s;
            dma_rdata_r <= dma_rdata_nxt_s;
            cpu_ack_r   <= cpu_ack_nxt_s;
            dma_ack_r   <= dma_ack_nxt_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_dma_r  <= last_dma_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=1 instance.
// Tie-break expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;

    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_ack, dma_ack, mem_rd, mem_wr;
    logic [31:0] cpu_rdata1, dma_rdata1, mem_addr1, mem_wdata1;
    logic        cpu_ack1, dma_ack1, mem_rd1, mem_wr1;

    int tests_run;
    int tests_failed;

    mem_arbiter #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata1), .dma_ack(dma_ack1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rd(mem_rd1), .mem_wr(mem_wr1),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs {mem_rd, mem_wr, cpu_ack, dma_ack} of the main instance.
    function automatic logic [31:0] ctl();
        return {28'd0, mem_rd, mem_wr, cpu_ack, dma_ack};
    endfunction

    logic        exp_dma [4];
    logic [31:0] rd_word;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
        mem_rdata = 32'd0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_ctl",   ctl(),     32'h0);
        check("rst_addr",  mem_addr,  32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_crd",   cpu_rdata, 32'h0);
        check("rst_drd",   dma_rdata, 32'h0);

        // CPU read at 0x100
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
        step();
        check("rd_c1_ctl",  ctl(),    32'h8);
        check("rd_c1_addr", mem_addr, 32'h100);
        step();
        check("rd_c2_ctl",  ctl(),    32'h8);
        step();
        check("rd_c3_ctl",  ctl(),     32'h2);
        check("rd_c3_data", cpu_rdata, 32'hDEADBEEF);
        check("rd_c3_drd",  dma_rdata, 32'h0);
        cpu_req = 1'b0;
        step();
        check("rd_c4_ctl",  ctl(),    32'h0);

        // DMA write of 0x12345678 to 0x40
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
        mem_rdata = 32'hCAFEF00D;
        step();
        check("wr_c1_ctl",   ctl(),     32'h4);
        check("wr_c1_addr",  mem_addr,  32'h40);
        check("wr_c1_wdata", mem_wdata, 32'h12345678);
        step();
        check("wr_c2_ctl",   ctl(),     32'h4);
        step();
        check("wr_c3_ctl",   ctl(),     32'h1);
        check("wr_c3_crd",   cpu_rdata, 32'hDEADBEEF);
        dma_req = 1'b0; dma_we = 1'b0;
        step();
        check("wr_c4_ctl",   ctl(),     32'h0);

        // Both requests held for four accesses; previous grant was DMA
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_dma[0] = 1'b0; exp_dma[1] = 1'b1; exp_dma[2] = 1'b0; exp_dma[3] = 1'b1;
`else
        exp_dma[0] = 1'b0; exp_dma[1] = 1'b0; exp_dma[2] = 1'b0; exp_dma[3] = 1'b0;
`endif
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300;
        for (int i = 0; i < 4; i++) begin
            rd_word = 32'hA0000000 + 32'(i);
            mem_rdata = rd_word;
            step();
            check($sformatf("tie%0d_addr", i), mem_addr, exp_dma[i] ? 32'h300 : 32'h200);
            step();
            step();
            check($sformatf("tie%0d_ctl", i), ctl(), exp_dma[i] ? 32'h1 : 32'h2);
            check($sformatf("tie%0d_data", i), exp_dma[i] ? dma_rdata : cpu_rdata, rd_word);
            step();
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        step();
        check("tie_end_ctl", ctl(), 32'h0);

        // Reset in the second ACCESS cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80; mem_rdata = 32'h11111111;
        step();
        step();
        check("ab_c2_ctl", ctl(), 32'h8);
        rst = 1'b1;
        step();
        rst = 1'b0; cpu_req = 1'b0;
        check("ab_c3_ctl",  ctl(),     32'h0);
        check("ab_c3_addr", mem_addr,  32'h0);
        check("ab_c3_crd",  cpu_rdata, 32'h0);
        check("ab_c3_drd",  dma_rdata, 32'h0);
        step();
        check("ab_c4_ctl",  ctl(),     32'h0);

        // WAIT_CYCLES=1 with address changed mid-access
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500; mem_rdata = 32'h55AA55AA;
        step();
        check("w1_c1_rd",   {31'd0, mem_rd1},  32'h1);
        check("w1_c1_ack",  {31'd0, cpu_ack1}, 32'h0);
        check("w1_c1_addr", mem_addr1,         32'h500);
        cpu_addr = 32'h999;
        step();
        check("w1_c2_ack",  {31'd0, cpu_ack1}, 32'h1);
        check("w1_c2_rd",   {31'd0, mem_rd1},  32'h0);
        check("w1_c2_data", cpu_rdata1,        32'h55AA55AA);
        check("w1_c2_addr", mem_addr1,         32'h500);
        check("w2_c2_addr", mem_addr,          32'h500);
        check("w2_c2_ctl",  ctl(),             32'h8);
        step();
        cpu_req = 1'b0;
        check("w2_c3_ctl",  ctl(),             32'h2);
        check("w2_c3_data", cpu_rdata,         32'h55AA55AA);
        check("w1_c3_ack",  {31'd0, cpu_ack1}, 32'h0);
        step();
        check("w2_c4_ctl",  ctl(),             32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
